// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer
// Turns parallel words into a serial bit stream (x / x_valid) that feeds a
// 1010 pattern detector. It holds one active word in a shift register and
// buffers one more word in a pending register, so a steady producer keeps
// x_valid high without gaps.
//
// Ports
//   clk       : single clock, all state updates on its rising edge
//   rst       : synchronous, active-high reset
//   din       : parallel word offered for transfer
//   din_valid : din holds a word
//   din_ready : a word can be accepted this cycle (pending slot empty)
//   x         : serial data bit, forced to 0 when x_valid is low
//   x_valid   : x carries a real data bit (state SHIFT)
//   busy      : a word is being shifted or one is pending
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] pend_q;
  logic             pend_full_q, pend_full_d;
  logic             load_pend;
  logic             accept;

  // Advance the shift register by one bit; the bit on x always sits at the
  // output end, so the register moves toward that end.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) shift_step = {v[WIDTH-2:0], 1'b0};
    else           shift_step = {1'b0, v[WIDTH-1:1]};
  endfunction

  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) out_bit = v[WIDTH-1];
    else           out_bit = v[0];
  endfunction

  // Outputs depend only on registered state and rst, never on din/din_valid.
  assign din_ready = ~pend_full_q & ~rst;
  assign accept    = din_valid & din_ready;
  assign x_valid   = (state_q == SHIFT) & ~rst;
  assign x         = x_valid ? out_bit(sreg_q) : 1'b0;
  assign busy      = ((state_q == SHIFT) | pend_full_q) & ~rst;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sreg_d      = sreg_q;
    pend_full_d = pend_full_q;
    load_pend   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d  = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          // Last bit of the active word ends here: chain the next word
          // in without a gap if one is available, else fall back to IDLE.
          cnt_d = '0;
          if (pend_full_q) begin
            sreg_d      = pend_q;
            pend_full_d = 1'b0;
          end else if (accept) begin
            sreg_d = din;
          end else begin
            sreg_d  = '0;
            state_d = IDLE;
          end
        end else begin
          sreg_d = shift_step(sreg_q);
          cnt_d  = cnt_q + 1'b1;
          if (accept) begin
            load_pend   = 1'b1;
            pend_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sreg_q      <= '0;
      pend_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sreg_q      <= sreg_d;
      pend_full_q <= pend_full_d;
    end
  end

  // Pending data needs no reset: pend_full_q alone says whether it is live.
  always_ff @(posedge clk) begin
    if (load_pend) pend_q <= din;
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
module tb_seq_bit_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din, din2;
  logic         dv, dv2;
  logic         rdy1, x1, xv1, busy1;
  logic         rdy2, x2, xv2, busy2;

  int total = 0;
  int bad   = 0;
  bit q1[$];
  bit q2[$];

  always #5 clk = ~clk;

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(dv), .din_ready(rdy1),
    .x(x1), .x_valid(xv1), .busy(busy1)
  );

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din2), .din_valid(dv2), .din_ready(rdy2),
    .x(x2), .x_valid(xv2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: model acceptance from the bench's own view of the pending
  // slot (queue holds more than one word => pending full), retire the bit
  // that was on x, append accepted words, then check all outputs.
  task automatic tick();
    bit           r;
    bit           a1, a2;
    logic [W-1:0] d1, d2;
    logic         ev, ex, er;
    r  = rst;
    a1 = dv  && !rst && (q1.size() <= W);
    a2 = dv2 && !rst && (q2.size() <= W);
    d1 = din;
    d2 = din2;
    @(posedge clk);
    if (r) begin
      q1.delete();
      q2.delete();
    end else begin
      if (q1.size() > 0) void'(q1.pop_front());
      if (q2.size() > 0) void'(q2.pop_front());
      if (a1) for (int i = W - 1; i >= 0; i--) q1.push_back(d1[i]);
      if (a2) for (int i = 0; i < W; i++) q2.push_back(d2[i]);
    end
    #1;
    ev = !rst && (q1.size() > 0);
    ex = ev ? q1[0] : 1'b0;
    er = !rst && (q1.size() <= W);
    chk("msb_x_valid", xv1, ev);
    chk("msb_x", x1, ex);
    chk("msb_busy", busy1, ev);
    chk("msb_din_ready", rdy1, er);
    ev = !rst && (q2.size() > 0);
    ex = ev ? q2[0] : 1'b0;
    er = !rst && (q2.size() <= W);
    chk("lsb_x_valid", xv2, ev);
    chk("lsb_x", x2, ex);
    chk("lsb_busy", busy2, ev);
    chk("lsb_din_ready", rdy2, er);
  endtask

  initial begin
    rst  = 1'b1;
    dv   = 1'b0;
    dv2  = 1'b0;
    din  = '0;
    din2 = '0;

    // reset held two cycles: everything low
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("msb_ready_after_rst", rdy1, 1'b1);
    chk("lsb_ready_after_rst", rdy2, 1'b1);

    // single word A5 from IDLE
    din = 8'hA5; dv = 1'b1;
    tick();
    dv = 1'b0;
    repeat (9) tick();

    // back-to-back AA, 0F, then 3C held under backpressure
    din = 8'hAA; dv = 1'b1;
    tick();
    din = 8'h0F;
    tick();
    din = 8'h3C;
    repeat (8) tick();
    dv = 1'b0;
    repeat (20) tick();

    // reset after 3 bits of FF with 55 pending
    din = 8'hFF; dv = 1'b1;
    tick();
    din = 8'h55;
    tick();
    dv = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (14) tick();

    // LSB-first word 05
    din2 = 8'h05; dv2 = 1'b1;
    tick();
    dv2 = 1'b0;
    repeat (9) tick();

    // words queued but never seen would be lost bits
    chk("msb_queue_drained", q1.size() == 0, 1'b1);
    chk("lsb_queue_drained", q2.size() == 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_bit_serializer.md
SEQ_BIT_SERIALIZER -- requirements
Module: seq_bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: parallel word width, minimum 2.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = shift out MSB first, 0 = shift out LSB first.
REQ-003 SHALL have clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst  input  1  one clock; reset is synchronous and active-high.
REQ-005 SHALL have din  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have din_valid  input  1  din holds a word offered for transfer.
REQ-007 SHALL have din_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have x  output  1  serial bit stream that drives the 1010 detector data input.
REQ-009 SHALL have x_valid  output  1  x carries a real data bit this cycle.
REQ-010 SHALL have busy  output  1  a word is being shifted or is pending.

Function
REQ-011 SHALL transfer a word at a rising edge where din_valid=1 and din_ready=1, and at no other edge.
REQ-012 SHALL hold two storage slots: a shift register (active word) and a pending register (one-word buffer).
REQ-013 SHALL implement states IDLE and SHIFT, plus a bit counter of width clog2(WIDTH).
REQ-014 IDLE: an accepted word loads the shift register, the counter clears to 0 and the state goes to SHIFT.
REQ-015 SHIFT: an accepted word loads the pending register; the shift register advances one bit per cycle and the counter increments.
REQ-016 SHALL derive x from shift-register state only: MSB when MSB_FIRST=1, LSB otherwise; there SHALL be no combinational path from din or din_valid to x or x_valid.
REQ-017 SHALL drive x_valid=1 exactly when state=SHIFT, and force x=0 whenever x_valid=0.
REQ-018 Latency: a word accepted at edge k SHALL present its first bit on x from edge k until edge k+1; the following bits SHALL appear on the next WIDTH-1 consecutive cycles.
REQ-019 At the edge ending the last bit (counter=WIDTH-1), if pending is full, SHALL move pending into the shift register, clear pending, clear the counter and stay in SHIFT (no gap cycle).
REQ-020 At that same edge, if pending is empty and a word is accepted, SHALL load that word directly into the shift register and stay in SHIFT (no gap cycle).
REQ-021 At that same edge, if pending is empty and no word is accepted, SHALL go to IDLE.
REQ-022 SHALL drive din_ready = (pending empty) AND NOT rst; a word SHALL never be accepted while pending is full.
REQ-023 SHALL drive busy = (state=SHIFT) OR (pending full).
REQ-024 With din_valid held high, SHALL stream words at full rate: x_valid high continuously, WIDTH bits per word.

Reset
REQ-025 SHALL clear state to IDLE, counter to 0, pending to empty and the shift register to 0 on any rising edge with rst=1, including mid-word.
REQ-026 SHALL drive x=0, x_valid=0, busy=0 and din_ready=0 while rst=1.
REQ-027 SHALL drive din_ready=1 in the first cycle after rst deasserts.
REQ-028 SHALL discard the active word and any pending word on reset; their remaining bits SHALL never appear on x.

Verification
REQ-029 Reset: rst=1 for 2 cycles -> x=0, x_valid=0, din_ready=0, busy=0 throughout; din_ready=1 in the first cycle after release.
REQ-030 Single word: WIDTH=8, MSB_FIRST=1, din=8'hA5 accepted from IDLE -> x=1,0,1,0,0,1,0,1 on 8 consecutive cycles with x_valid=1 for exactly those cycles, then IDLE with busy=0.
REQ-031 Back-to-back: 8'hAA then 8'h0F offered with din_valid held high -> 16 contiguous valid bits 1010101000001111.
REQ-032 Back-to-back pending timing: 8'h0F enters pending one edge after 8'hAA is accepted; din_ready=0 from then until the edge that ends bit 8 of 8'hAA; din_ready=1 in the following cycle.
REQ-033 Backpressure: a third word 8'h3C held with din_valid=1 while din_ready=0 -> it is accepted only when din_ready=1, then emitted intact right after 8'h0F with no gap.
REQ-034 Reset mid-word: rst pulsed for 1 cycle after 3 bits of 8'hFF, with 8'h55 pending -> x_valid=0 in the cycle after the reset edge; the remaining 5 bits of 8'hFF and all of 8'h55 never appear.
REQ-035 LSB-first: MSB_FIRST=0, din=8'h05 -> x=1,0,1,0,0,0,0,0.
